// File: rtl/vector_append_pkg.sv
// Shared types and helpers for the vector append pipeline.
package vector_append_pkg;

    typedef enum logic [1:0] {
        MODE_APPEND  = 2'd0,
        MODE_REV_A   = 2'd1,
        MODE_REV_ALL = 2'd2,
        MODE_SWAP    = 2'd3
    } mode_e;

    // Output word width: selected A slice, pad and selected B slice, all W bits per element.
    function automatic int unsigned calc_ow(input int unsigned w, input int unsigned sel_a,
                                            input int unsigned pad, input int unsigned sel_b);
        return w * (sel_a + pad + sel_b);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register stage: data, valid bit and the ready equation.
module pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid_i,
    input  logic [DW-1:0] up_data_i,
    input  logic          dn_ready_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // An empty stage, or one that drains this cycle, can take a new beat.
    assign ready_o = !valid_q || dn_ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next state: load from upstream when ready; data only moves with a valid beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/vector_append_pipe.sv
// Slice/pad/reverse of two element vectors followed by a valid/ready register pipeline.
module vector_append_pipe
    import vector_append_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned NA     = 8,
    parameter int unsigned NB     = 8,
    parameter int unsigned SEL_A  = 4,
    parameter int unsigned SEL_B  = 3,
    parameter int unsigned PAD    = 1,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [W*NA-1:0]                           __in0,
    input  logic [W*NB-1:0]                           __in1,
    input  logic [1:0]                                mode,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [calc_ow(W, SEL_A, PAD, SEL_B)-1:0]  __out0,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CNT_W-1:0]                          count
);

    localparam int unsigned NE = SEL_A + PAD + SEL_B;
    localparam int unsigned OW = calc_ow(W, SEL_A, PAD, SEL_B);

    if (SEL_A < 1 || SEL_A > NA) begin : g_err_sel_a
        $error("SEL_A must be in 1..NA");
    end
    if (SEL_B < 1 || SEL_B > NB) begin : g_err_sel_b
        $error("SEL_B must be in 1..NB");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_err_stages
        $error("STAGES must be in 1..4");
    end

    mode_e                   mode_sel;
    logic [W-1:0]            base_el [NE];
    logic [W-1:0]            res_el  [NE];
    logic [OW-1:0]           in_word;
    logic [STAGES:0]         st_valid;
    logic [STAGES:0]         st_ready;
    logic [STAGES:0][OW-1:0] st_data;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    unused_in;

    assign mode_sel  = mode_e'(mode);
    // Elements outside the selected slices are intentionally dropped.
    assign unused_in = ^{__in0, __in1};

    // Mode-0 arrangement {SA, Z, SB}; element 0 is the least significant.
    always_comb begin
        for (int k = 0; k < NE; k++) begin
            base_el[k] = '0;
        end
        for (int j = 0; j < SEL_B; j++) begin
            base_el[j] = __in1[W*j +: W];
        end
        for (int j = 0; j < SEL_A; j++) begin
            base_el[SEL_B+PAD+j] = __in0[W*(NA-SEL_A+j) +: W];
        end
    end

    // Every other mode is a permutation of the mode-0 elements.
    always_comb begin
        for (int k = 0; k < NE; k++) begin
            res_el[k] = base_el[k];
        end
        unique case (mode_sel)
            MODE_APPEND: ;
            MODE_REV_A: begin
                for (int j = 0; j < SEL_A; j++) begin
                    res_el[SEL_B+PAD+j] = base_el[SEL_B+PAD+SEL_A-1-j];
                end
            end
            MODE_REV_ALL: begin
                for (int k = 0; k < NE; k++) begin
                    res_el[k] = base_el[NE-1-k];
                end
            end
            MODE_SWAP: begin
                for (int j = 0; j < SEL_A; j++) begin
                    res_el[j] = base_el[SEL_B+PAD+j];
                end
                for (int j = 0; j < PAD; j++) begin
                    res_el[SEL_A+j] = '0;
                end
                for (int j = 0; j < SEL_B; j++) begin
                    res_el[SEL_A+PAD+j] = base_el[j];
                end
            end
            default: ;
        endcase
    end

    // Pack result elements into the flat input word of stage 0.
    always_comb begin
        in_word = '0;
        for (int k = 0; k < NE; k++) begin
            in_word[W*k +: W] = res_el[k];
        end
    end

    assign st_valid[0]      = in_valid;
    assign st_data[0]       = in_word;
    assign st_ready[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_stage #(
            .DW (OW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid_i (st_valid[i]),
            .up_data_i  (st_data[i]),
            .dn_ready_i (st_ready[i+1]),
            .ready_o    (st_ready[i]),
            .valid_o    (st_valid[i+1]),
            .data_o     (st_data[i+1])
        );
    end

    assign in_ready  = st_ready[0];
    assign out_valid = st_valid[STAGES];
    assign __out0    = st_data[STAGES];
    assign count     = count_q;

    // Accepted-beat counter, wraps naturally at 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (in_valid && in_ready) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_vector_append_pipe.sv
// Randomised and directed bench for vector_append_pipe with a queue-based reference model.
module tb_vector_append_pipe;

    localparam int STG   = 2;
    localparam int STG_S = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT plus a CNT_W=4 twin sharing its inputs.
    logic        rst;
    logic [63:0] in0, in1, out0, out0_c;
    logic [1:0]  mode;
    logic        in_valid, in_ready, out_valid, out_ready, in_ready_c, out_valid_c;
    logic [15:0] count;
    logic [3:0]  count_c;

    // Parameter-sweep DUT.
    logic        rst_s;
    logic [23:0] in0_s;
    logic [19:0] in1_s;
    logic [27:0] out0_s;
    logic [1:0]  mode_s;
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [15:0] count_s;

    int n_err = 0;
    int n_checks = 0;
    logic done_s = 1'b0;

    vector_append_pipe u_dut (
        .clk(clk), .rst(rst), .__in0(in0), .__in1(in1), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .__out0(out0), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    vector_append_pipe #(.CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .__in0(in0), .__in1(in1), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_c), .__out0(out0_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .count(count_c)
    );

    vector_append_pipe #(
        .W(4), .NA(6), .NB(5), .SEL_A(2), .SEL_B(5), .PAD(0), .STAGES(1)
    ) u_dut_s (
        .clk(clk), .rst(rst_s), .__in0(in0_s), .__in1(in1_s), .mode(mode_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .__out0(out0_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .count(count_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: build element lists MSB first from the mode rules, then pack.
    function automatic logic [63:0] ref_word(input int w, input int na, input int sela,
                                             input int selb, input int pad,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input int m);
        int sa[$];
        int sb[$];
        int word[$];
        int tmp[$];
        logic [63:0] msk, r;
        msk = (64'd1 << w) - 64'd1;
        for (int k = na - 1; k >= na - sela; k--) sa.push_back(int'((a >> (w * k)) & msk));
        for (int k = selb - 1; k >= 0; k--) sb.push_back(int'((b >> (w * k)) & msk));
        case (m)
            1: begin
                for (int i = sela - 1; i >= 0; i--) word.push_back(sa[i]);
                repeat (pad) word.push_back(0);
                foreach (sb[i]) word.push_back(sb[i]);
            end
            3: begin
                foreach (sb[i]) word.push_back(sb[i]);
                repeat (pad) word.push_back(0);
                foreach (sa[i]) word.push_back(sa[i]);
            end
            default: begin
                foreach (sa[i]) word.push_back(sa[i]);
                repeat (pad) word.push_back(0);
                foreach (sb[i]) word.push_back(sb[i]);
                if (m == 2) begin
                    tmp = word;
                    word.delete();
                    for (int i = tmp.size() - 1; i >= 0; i--) word.push_back(tmp[i]);
                end
            end
        endcase
        r = '0;
        foreach (word[i]) r = (r << w) | 64'(word[i]);
        return r;
    endfunction

    // ---------------- monitor / scoreboard for the default DUT ----------------
    logic [63:0] exp_q[$];
    int          acc_q[$];
    int          cyc = 0;
    int          last_stall = -1;
    logic [31:0] mcount = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_out = '0;
    logic        rst_seen = 1'b0;
    int          n_out = 0, streak = 0, best_streak = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            mcount = 0;
            prev_hold = 1'b0;
            rst_seen = 1'b1;
            n_out = 0;
            streak = 0;
            best_streak = 0;
        end else begin
            if (rst_seen) begin
                check("post_reset_out_valid", 64'(out_valid), 64'd0);
                check("post_reset_out0", out0, 64'd0);
                check("post_reset_in_ready", 64'(in_ready), 64'd1);
                rst_seen = 1'b0;
            end
            check("count", 64'(count), 64'(mcount[15:0]));
            check("count_w4", 64'(count_c), 64'(mcount[3:0]));
            check("twin_out_valid", 64'(out_valid_c), 64'(out_valid));
            check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == STG && !out_ready)));
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out0, prev_out);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stale_beat", 64'd1, 64'd0);
                end else begin
                    check("data", out0, exp_q[0]);
                    if (out_ready) begin
                        if (last_stall < acc_q[0]) check("latency", 64'(cyc - acc_q[0]), 64'(STG));
                        else check("latency_min", 64'((cyc - acc_q[0]) >= STG), 64'd1);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                streak++;
                if (streak > best_streak) best_streak = streak;
            end else begin
                streak = 0;
            end
            prev_hold = out_valid && !out_ready;
            prev_out = out0;
            if (!out_ready) last_stall = cyc;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_word(8, 8, 4, 3, 1, in0, in1, int'(mode)));
                acc_q.push_back(cyc);
                mcount++;
            end
        end
    end

    // ---------------- monitor / scoreboard for the sweep DUT ----------------
    logic [63:0] exp_qs[$];
    int          acc_qs[$];
    int          last_stall_s = -1;
    logic [31:0] mcount_s = 0;
    logic        prev_hold_s = 1'b0;
    logic [27:0] prev_out_s = '0;

    always @(negedge clk) begin
        if (rst_s) begin
            exp_qs.delete();
            acc_qs.delete();
            mcount_s = 0;
            prev_hold_s = 1'b0;
        end else begin
            check("s_count", 64'(count_s), 64'(mcount_s[15:0]));
            check("s_in_ready", 64'(in_ready_s), 64'(!(exp_qs.size() == STG_S && !out_ready_s)));
            if (prev_hold_s) check("s_hold_data", 64'(out0_s), 64'(prev_out_s));
            if (out_valid_s) begin
                if (exp_qs.size() == 0) begin
                    check("s_stale_beat", 64'd1, 64'd0);
                end else begin
                    check("s_data", 64'(out0_s), exp_qs[0]);
                    if (out_ready_s) begin
                        if (last_stall_s < acc_qs[0])
                            check("s_latency", 64'(cyc - acc_qs[0]), 64'(STG_S));
                        else check("s_latency_min", 64'((cyc - acc_qs[0]) >= STG_S), 64'd1);
                        void'(exp_qs.pop_front());
                        void'(acc_qs.pop_front());
                    end
                end
            end
            prev_hold_s = out_valid_s && !out_ready_s;
            prev_out_s = out0_s;
            if (!out_ready_s) last_stall_s = cyc;
            if (in_valid_s && in_ready_s) begin
                exp_qs.push_back(ref_word(4, 6, 2, 5, 0, 64'(in0_s), 64'(in1_s), int'(mode_s)));
                acc_qs.push_back(cyc);
                mcount_s++;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 2) ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m);
        int t;
        t = 0;
        in0 = a;
        in1 = b;
        mode = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic rand_beat();
        in0 = {$urandom, $urandom};
        in1 = {$urandom, $urandom};
        mode = 2'($urandom_range(0, 3));
    endtask

    // ---------------- sweep stimulus ----------------
    initial begin
        rst_s = 1'b1;
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        in0_s = '0;
        in1_s = '0;
        mode_s = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_s = 1'b0;
        @(negedge clk);
        check("s_reset_out_valid", 64'(out_valid_s), 64'd0);
        check("s_reset_in_ready", 64'(in_ready_s), 64'd1);
        @(posedge clk);
        #2;
        repeat (400) begin
            in0_s = 24'($urandom);
            in1_s = 20'($urandom);
            mode_s = 2'($urandom_range(0, 3));
            in_valid_s = ($urandom_range(0, 3) != 0);
            out_ready_s = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #2;
        end
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("s_drained", 64'(exp_qs.size()), 64'd0);
        check("s_count_total", 64'(count_s), 64'(mcount_s[15:0]));
        done_s = 1'b1;
    end

    // ---------------- main directed + random sequence ----------------
    logic [63:0] lit_a, lit_b;
    logic [63:0] lit[4];
    int hold_cnt;

    initial begin
        lit_a = 64'h0123456789ABCDEF;
        lit_b = 64'hFEDCBA9876543210;
        lit[0] = 64'h0123456700543210;
        lit[1] = 64'h6745230100543210;
        lit[2] = 64'h1032540067452301;
        lit[3] = 64'h5432100001234567;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in0 = '0;
        in1 = '0;
        mode = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_out0", out0, 64'd0);
        @(posedge clk);
        #2;

        // Known-answer vectors, each appearing exactly STG cycles after acceptance.
        for (int i = 0; i < 4; i++) begin
            check("model_literal", ref_word(8, 8, 4, 3, 1, lit_a, lit_b, i), lit[i]);
            send(lit_a, lit_b, 2'(i));
            @(negedge clk);
            check("lit_early_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            check("lit_valid", 64'(out_valid), 64'd1);
            check("lit_data", out0, lit[i]);
            @(posedge clk);
            #2;
        end

        // Eight back-to-back beats.
        do_reset();
        repeat (8) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("b2b_count", 64'(count), 64'd8);
        check("b2b_outputs", 64'(n_out), 64'd8);
        check("b2b_streak", 64'(best_streak), 64'd8);

        // Backpressure: fill, stall, then release.
        do_reset();
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            hold_cnt = int'(in_ready);
            @(posedge clk);
            #2;
            if (hold_cnt != 0) rand_beat();
        end
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_count", 64'(count), 64'd2);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("bp_outputs", 64'(n_out), 64'd2);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight.
        do_reset();
        repeat (2) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #2;
        check("midrst_no_output", 64'(n_out), 64'd0);

        // Counter wrap on the CNT_W=4 twin.
        do_reset();
        repeat (17) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap_count_w4", 64'(count_c), 64'd1);
        check("wrap_count_w16", 64'(count), 64'd17);
        @(posedge clk);
        #2;

        // Random traffic with random backpressure.
        repeat (400) begin
            rand_beat();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        hold_cnt = 0;
        while (!done_s && hold_cnt < 2000) begin
            hold_cnt++;
            @(posedge clk);
        end
        if (!done_s) check("sweep_timeout", 64'd0, 64'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
